// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the instruction-fetch slice.
//   - fetch_state_t : FETCH/HOLD state encoding
//   - DEF_RESET_PC / DEF_EXC_PC : default reset and address-error vectors
//   - OPCODE_*/FUNCT_* : instruction field positions
//   - branch_offset() : sign-extended, word-scaled branch displacement
package mips_pkg;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } fetch_state_t;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_PC   = 32'h0000_4180;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;

    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/pc_next.sv
// pc_next: combinational next-PC selection.
//   i_pc_mux, i_ifj, i_branch : control-unit selects (jump beats branch)
//   i_rs_data                 : register jump target
//   i_instr_idx               : Instr[25:0] (jump index, low 16 = branch imm)
//   i_pc_plus4                : PC+4 of the held instruction
//   o_next_pc                 : raw next PC (alignment handled by the caller)
module pc_next
    import mips_pkg::*;
(
    input  logic        i_pc_mux,
    input  logic        i_ifj,
    input  logic        i_branch,
    input  logic [31:0] i_rs_data,
    input  logic [25:0] i_instr_idx,
    input  logic [31:0] i_pc_plus4,
    output logic [31:0] o_next_pc
);

    always_comb begin
        o_next_pc = i_pc_plus4;
        if (i_pc_mux && i_ifj) begin
            o_next_pc = i_rs_data;
        end else if (i_pc_mux) begin
            o_next_pc = {i_pc_plus4[31:28], i_instr_idx, 2'b00};
        end else if (i_branch) begin
            // 32-bit add wraps naturally for negative offsets
            o_next_pc = i_pc_plus4 + branch_offset(i_instr_idx[15:0]);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: two-state instruction fetch with hold/stall and next-PC update.
// Ports:
//   clk, rstn                 : clock, async active-low reset
//   Imem_Req/Addr/Ready/Data  : instruction-memory request handshake
//   Instr, Instr_Valid        : held instruction and its valid flag
//   opcode, Funct             : decode fields of Instr
//   PC, PC_Plus4              : address of Instr and its successor
//   PC_MUX, IFJ, Branch       : next-PC selects; Rs_Data register target
//   Stall                     : downstream hold (honoured in HOLD only)
//   Addr_Err                  : one-cycle pulse on misaligned next-PC
// Build option: FETCH_ALIGN_CHECK_EN compiles in the misaligned-PC trap to
// EXC_PC; without it the low two next-PC bits are simply cleared.
//
// state | meaning
// FETCH | request outstanding at PC, waiting for Imem_Ready
// HOLD  | Instr valid, retires on the first cycle with Stall=0
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] EXC_PC   = DEF_EXC_PC
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        Imem_Req,
    output logic [31:0] Imem_Addr,
    input  logic        Imem_Ready,
    input  logic [31:0] Imem_Data,
    output logic [31:0] Instr,
    output logic        Instr_Valid,
    output logic [5:0]  opcode,
    output logic [5:0]  Funct,
    output logic [31:0] PC,
    output logic [31:0] PC_Plus4,
    input  logic        PC_MUX,
    input  logic        IFJ,
    input  logic        Branch,
    input  logic [31:0] Rs_Data,
    input  logic        Stall,
    output logic        Addr_Err
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_instr;
    logic         r_req;
    logic         r_valid;
    logic         r_addr_err;

    logic [31:0]  w_pc_plus4;
    logic [31:0]  w_next_raw;
    logic [31:0]  w_next_pc;
    logic         w_misaligned;

    assign w_pc_plus4 = r_pc + 32'd4;

    pc_next u_pc_next (
        .i_pc_mux    (PC_MUX),
        .i_ifj       (IFJ),
        .i_branch    (Branch),
        .i_rs_data   (Rs_Data),
        .i_instr_idx (r_instr[25:0]),
        .i_pc_plus4  (w_pc_plus4),
        .o_next_pc   (w_next_raw)
    );

`ifdef FETCH_ALIGN_CHECK_EN
    assign w_misaligned = |w_next_raw[1:0];
    assign w_next_pc    = w_misaligned ? EXC_PC : w_next_raw;
`else
    assign w_misaligned = 1'b0;
    assign w_next_pc    = w_next_raw & 32'hFFFF_FFFC;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_FETCH;
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_req      <= 1'b0;
            r_valid    <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= 1'b0;
            case (r_state)
                ST_FETCH: begin
                    // request comes up on the first clock out of reset and
                    // stays up until the memory completes it
                    r_req <= 1'b1;
                    if (r_req && Imem_Ready) begin
                        r_state <= ST_HOLD;
                        r_instr <= Imem_Data;
                        r_req   <= 1'b0;
                        r_valid <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!Stall) begin
                        r_state    <= ST_FETCH;
                        r_pc       <= w_next_pc;
                        r_req      <= 1'b1;
                        r_valid    <= 1'b0;
                        r_addr_err <= w_misaligned;
                    end
                end
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    assign Imem_Req    = r_req;
    assign Imem_Addr   = r_pc;
    assign Instr       = r_instr;
    assign Instr_Valid = r_valid;
    assign opcode      = r_instr[OPCODE_MSB:OPCODE_LSB];
    assign Funct       = r_instr[FUNCT_MSB:FUNCT_LSB];
    assign PC          = r_pc;
    assign PC_Plus4    = w_pc_plus4;
    assign Addr_Err    = r_addr_err;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk;
    logic        rstn;
    logic        Imem_Req;
    logic [31:0] Imem_Addr;
    logic        Imem_Ready;
    logic [31:0] Imem_Data;
    logic [31:0] Instr;
    logic        Instr_Valid;
    logic [5:0]  opcode;
    logic [5:0]  Funct;
    logic [31:0] PC;
    logic [31:0] PC_Plus4;
    logic        PC_MUX;
    logic        IFJ;
    logic        Branch;
    logic [31:0] Rs_Data;
    logic        Stall;
    logic        Addr_Err;

    fetch_unit dut (
        .clk         (clk),
        .rstn        (rstn),
        .Imem_Req    (Imem_Req),
        .Imem_Addr   (Imem_Addr),
        .Imem_Ready  (Imem_Ready),
        .Imem_Data   (Imem_Data),
        .Instr       (Instr),
        .Instr_Valid (Instr_Valid),
        .opcode      (opcode),
        .Funct       (Funct),
        .PC          (PC),
        .PC_Plus4    (PC_Plus4),
        .PC_MUX      (PC_MUX),
        .IFJ         (IFJ),
        .Branch      (Branch),
        .Rs_Data     (Rs_Data),
        .Stall       (Stall),
        .Addr_Err    (Addr_Err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [3:0]  lat;
        logic        pc_mux;
        logic        ifj;
        logic        branch;
        logic [31:0] rs;
        logic [3:0]  stall;
        logic [31:0] pc;
        logic [31:0] next_pc;
        logic        err;
    } vec_t;

    localparam int NV = 14;
    vec_t tbl [NV];

    logic [31:0] exp_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sb_pop(output logic [31:0] v);
        if (exp_q.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
            v = 32'hXXXX_XXXX;
        end else begin
            v = exp_q.pop_front();
        end
    endtask

    // Serve one request: Ready on the lat-th request cycle; Stall is driven
    // high on that capture cycle and must be ignored in FETCH.
    task automatic fetch_serve(input logic [31:0] data, input logic [3:0] lat,
                               input logic [31:0] exp_pc);
        int n;
        logic [31:0] exp_addr;
        logic [31:0] exp_p4;
        n = 0;
        while (Imem_Req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", {31'd0, Imem_Req}, 32'd1);
        sb_pop(exp_addr);
        chk("imem_addr", Imem_Addr, exp_addr);
        chk("valid_in_fetch", {31'd0, Instr_Valid}, 32'd0);
        for (int c = 0; c < int'(lat); c++) begin
            if (c > 0) begin
                chk("addr_stable", Imem_Addr, exp_addr);
                chk("req_stable", {31'd0, Imem_Req}, 32'd1);
                chk("err_one_cycle", {31'd0, Addr_Err}, 32'd0);
            end
            Imem_Data  = data;
            Imem_Ready = (c == int'(lat) - 1);
            Stall      = (c == int'(lat) - 1);
            @(negedge clk);
        end
        Imem_Ready = 1'b0;
        Stall      = 1'b0;
        Imem_Data  = 32'hDEAD_BEEF;
        exp_p4 = exp_pc + 32'd4;
        chk("hold_valid", {31'd0, Instr_Valid}, 32'd1);
        chk("hold_req", {31'd0, Imem_Req}, 32'd0);
        chk("instr", Instr, data);
        chk("pc", PC, exp_pc);
        chk("pc_plus4", PC_Plus4, exp_p4);
        chk("opcode", {26'd0, opcode}, {26'd0, data[31:26]});
        chk("funct", {26'd0, Funct}, {26'd0, data[5:0]});
    endtask

    // Hold for v.stall cycles (with Imem_Ready noise), then retire.
    task automatic retire(input vec_t v);
        PC_MUX  = v.pc_mux;
        IFJ     = v.ifj;
        Branch  = v.branch;
        Rs_Data = v.rs;
        for (int s = 0; s < int'(v.stall); s++) begin
            Stall      = 1'b1;
            Imem_Ready = 1'b1;
            Imem_Data  = 32'hBAD0_0000 + s;
            @(negedge clk);
            chk("stall_pc", PC, v.pc);
            chk("stall_instr", Instr, v.instr);
            chk("stall_valid", {31'd0, Instr_Valid}, 32'd1);
            chk("stall_req", {31'd0, Imem_Req}, 32'd0);
            chk("stall_err", {31'd0, Addr_Err}, 32'd0);
        end
        Stall      = 1'b0;
        Imem_Ready = 1'b0;
        exp_q.push_back(v.next_pc);
        @(negedge clk);
        chk("retire_valid", {31'd0, Instr_Valid}, 32'd0);
        chk("retire_req", {31'd0, Imem_Req}, 32'd1);
        chk("retire_err", {31'd0, Addr_Err}, {31'd0, v.err});
        PC_MUX  = 1'b0;
        IFJ     = 1'b0;
        Branch  = 1'b0;
        Rs_Data = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] after_err;
        logic [31:0] exp_addr;
        vec_t        hv;

`ifdef FETCH_ALIGN_CHECK_EN
        after_err = 32'h0000_4180;
`else
        after_err = 32'h0000_3000;
`endif
        //          instr         lat    mux  ifj  br   rs             stl    pc             next                   err
        tbl[0]  = '{32'h2008_0005, 4'd3, 1'b0,1'b0,1'b0,32'h0,         4'd0, 32'h0000_3000, 32'h0000_3004,         1'b0};
        tbl[1]  = '{32'h1000_0002, 4'd1, 1'b0,1'b0,1'b1,32'h0,         4'd0, 32'h0000_3004, 32'h0000_3010,         1'b0};
        tbl[2]  = '{32'h1000_FFFE, 4'd2, 1'b0,1'b0,1'b1,32'h0,         4'd0, 32'h0000_3010, 32'h0000_300C,         1'b0};
        tbl[3]  = '{32'h0800_0C04, 4'd1, 1'b1,1'b0,1'b0,32'h0,         4'd0, 32'h0000_300C, 32'h0000_3010,         1'b0};
        tbl[4]  = '{32'h1000_FFFE, 4'd1, 1'b0,1'b0,1'b0,32'h0,         4'd0, 32'h0000_3010, 32'h0000_3014,         1'b0};
        tbl[5]  = '{32'h0080_0008, 4'd1, 1'b1,1'b1,1'b1,32'h0000_3020, 4'd0, 32'h0000_3014, 32'h0000_3020,         1'b0};
        tbl[6]  = '{32'h0000_0020, 4'd2, 1'b0,1'b0,1'b0,32'h0,         4'd4, 32'h0000_3020, 32'h0000_3024,         1'b0};
        tbl[7]  = '{32'h0BFF_FFFF, 4'd1, 1'b1,1'b0,1'b1,32'h0,         4'd0, 32'h0000_3024, 32'h0FFF_FFFC,         1'b0};
        tbl[8]  = '{32'h0000_0000, 4'd1, 1'b0,1'b0,1'b0,32'h0,         4'd0, 32'h0FFF_FFFC, 32'h1000_0000,         1'b0};
        tbl[9]  = '{32'h0080_0008, 4'd1, 1'b1,1'b1,1'b0,32'hFFFF_FFFC, 4'd0, 32'h1000_0000, 32'hFFFF_FFFC,         1'b0};
        tbl[10] = '{32'h0000_0000, 4'd1, 1'b0,1'b0,1'b0,32'h0,         4'd1, 32'hFFFF_FFFC, 32'h0000_0000,         1'b0};
        tbl[11] = '{32'h1000_FFFE, 4'd1, 1'b0,1'b0,1'b1,32'h0,         4'd0, 32'h0000_0000, 32'hFFFF_FFFC,         1'b0};
`ifdef FETCH_ALIGN_CHECK_EN
        tbl[12] = '{32'h0080_0008, 4'd1, 1'b1,1'b1,1'b0,32'h0000_3002, 4'd0, 32'hFFFF_FFFC, after_err,             1'b1};
`else
        tbl[12] = '{32'h0080_0008, 4'd1, 1'b1,1'b1,1'b0,32'h0000_3002, 4'd0, 32'hFFFF_FFFC, after_err,             1'b0};
`endif
        tbl[13] = '{32'h2008_0005, 4'd2, 1'b0,1'b0,1'b0,32'h0,         4'd0, after_err,     after_err + 32'd4,     1'b0};

        rstn       = 1'b0;
        Imem_Ready = 1'b0;
        Imem_Data  = 32'h0;
        PC_MUX     = 1'b0;
        IFJ        = 1'b0;
        Branch     = 1'b0;
        Rs_Data    = 32'h0;
        Stall      = 1'b0;

        @(negedge clk);
        @(negedge clk);
        chk("rst_req", {31'd0, Imem_Req}, 32'd0);
        chk("rst_valid", {31'd0, Instr_Valid}, 32'd0);
        chk("rst_instr", Instr, 32'h0);
        chk("rst_err", {31'd0, Addr_Err}, 32'd0);
        chk("rst_pc", PC, 32'h0000_3000);

        rstn = 1'b1;
        exp_q.push_back(32'h0000_3000);
        @(negedge clk);
        chk("req_after_reset", {31'd0, Imem_Req}, 32'd1);

        for (int i = 0; i < NV; i++) begin
            fetch_serve(tbl[i].instr, tbl[i].lat, tbl[i].pc);
            retire(tbl[i]);
        end

        // Jump to 0x3040, then reset while that request is pending.
        hv = '{32'h0800_0C10, 4'd1, 1'b1, 1'b0, 1'b0, 32'h0, 4'd0,
               after_err + 32'd4, 32'h0000_3040, 1'b0};
        fetch_serve(hv.instr, hv.lat, hv.pc);
        retire(hv);
        sb_pop(exp_addr);
        chk("pre_reset_addr", Imem_Addr, exp_addr);
        chk("pre_reset_req", {31'd0, Imem_Req}, 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("midfetch_rst_req", {31'd0, Imem_Req}, 32'd0);
        chk("midfetch_rst_pc", PC, 32'h0000_3000);
        chk("midfetch_rst_instr", Instr, 32'h0);
        chk("midfetch_rst_valid", {31'd0, Instr_Valid}, 32'd0);
        Imem_Ready = 1'b1;
        Imem_Data  = 32'h1234_5678;
        @(negedge clk);
        chk("rst_held_instr", Instr, 32'h0);
        Imem_Ready = 1'b0;
        rstn = 1'b1;
        exp_q.push_back(32'h0000_3000);
        @(negedge clk);
        chk("restart_req", {31'd0, Imem_Req}, 32'd1);
        hv = '{32'h2008_0005, 4'd2, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0,
               32'h0000_3000, 32'h0000_3004, 1'b0};
        fetch_serve(hv.instr, hv.lat, hv.pc);
        retire(hv);
        fetch_serve(32'h0000_0020, 4'd1, 32'h0000_3004);

        chk("sb_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, PC loaded on reset.
REQ-002 SHALL have parameter EXC_PC, default 32'h0000_4180, PC loaded on an address error.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rstn  in  1  asynchronous active-low reset.
REQ-006 Imem_Req  out  1  instruction-memory read request.
REQ-007 Imem_Addr  out  32  byte address of the request.
REQ-008 Imem_Ready  in  1  Imem_Data valid this cycle; completes the request.
REQ-009 Imem_Data  in  32  instruction word.
REQ-010 Instr  out  32  held instruction.
REQ-011 Instr_Valid  out  1  Instr, PC and decode fields are valid.
REQ-012 opcode  out  6  Instr[31:26].
REQ-013 Funct  out  6  Instr[5:0].
REQ-014 PC  out  32  address of Instr.
REQ-015 PC_Plus4  out  32  PC+4, used for link writes.
REQ-016 PC_MUX, IFJ, Branch  in  1 each  control-unit next-PC selects.
REQ-017 Rs_Data  in  32  register jump target.
REQ-018 Stall  in  1  downstream hold.
REQ-019 Addr_Err  out  1  misaligned next-PC pulse.

Function
REQ-020 SHALL implement the FSM states FETCH and HOLD.
- FETCH: Imem_Req=1, Imem_Addr=PC.
- FETCH to HOLD on Imem_Ready=1; Instr captured from Imem_Data at that edge.
REQ-021 SHALL keep Imem_Req=1 and Imem_Addr stable in FETCH until Imem_Ready; a request is never withdrawn except by reset.
REQ-022 SHALL drive Instr_Valid=1 only in HOLD.
- Stall is ignored in FETCH.
REQ-023 SHALL retire Instr in the HOLD cycle where Stall=0.
- PC updated to next-PC.
- State returns to FETCH.
- Minimum two cycles per instruction.
REQ-024 SHALL hold in HOLD while Stall=1: PC, Instr and outputs unchanged.
REQ-025 SHALL compute next-PC by priority:
- PC_MUX&IFJ: Rs_Data.
- PC_MUX&~IFJ: {PC_Plus4[31:28], Instr[25:0], 2'b00}.
- Branch: PC_Plus4 + (sign-extended Instr[15:0] << 2).
- Otherwise: PC_Plus4.
REQ-026 SHALL compute all PC arithmetic modulo 2^32.
- 32'hFFFF_FFFC + 4 = 0.
- Negative branch offsets wrap.
REQ-027 SHALL derive opcode, Funct and PC_Plus4 combinationally from the held Instr and PC.
REQ-028 SHALL ignore Imem_Ready while in HOLD.

Reset
REQ-029 SHALL, on rstn low, immediately force:
- state=FETCH, PC=RESET_PC.
- Imem_Req=0, Instr=0, Instr_Valid=0, Addr_Err=0.
REQ-030 SHALL abandon any in-flight request on reset mid-FETCH.
REQ-031 SHALL assert Imem_Req in the first clock after rstn deassertion, with Imem_Addr=RESET_PC.

Configuration
REQ-032 SHALL use macro FETCH_ALIGN_CHECK_EN to compile alignment checking in or out.
- Defined: a retiring next-PC with [1:0]!=0 loads EXC_PC instead and pulses Addr_Err high for exactly one cycle.
- Undefined: next-PC[1:0] forced to 2'b00; Addr_Err tied 0.

Structure
REQ-033 SHALL take from shared package mips_pkg:
- FSM state encoding.
- Default RESET_PC and EXC_PC constants.
- Opcode/funct field position constants.
REQ-034 SHALL place next-PC selection in combinational sub-module pc_next, instantiated once.

Verification
REQ-035 Reset release, Imem_Ready after 3 cycles with Imem_Data=32'h2008_0005 -> Imem_Addr=32'h3000 held for 3 cycles; then Instr_Valid=1, opcode=6'b001000, PC_Plus4=32'h3004.
REQ-036 HOLD at PC=32'h3010, Branch=1, Instr[15:0]=16'hFFFE -> next Imem_Addr=32'h300C; with Branch=0 -> 32'h3014.
REQ-037 HOLD at PC=32'h3000, PC_MUX=1, IFJ=0, Instr[25:0]=26'h0000C04 -> next Imem_Addr=32'h3010; IFJ=1, Rs_Data=32'h3020 -> 32'h3020.
REQ-038 Stall=1 for 4 HOLD cycles -> PC, Instr and Instr_Valid stable, Imem_Req=0; release -> single PC advance.
REQ-039 rstn pulsed low mid-FETCH at PC=32'h3040 -> Imem_Req=0 immediately; restart at 32'h3000.
REQ-040 FETCH_ALIGN_CHECK_EN defined, jr with Rs_Data=32'h3002 -> PC=32'h4180 and one-cycle Addr_Err; undefined -> PC=32'h3000, Addr_Err=0.
